// File: rtl/alu_operand_stage_if.sv
// Bus bundle for alu_operand_stage.
// It carries the decoder-side handshake (id_*) and the EX-side operand bus (ex_*, op1/op2, field).
interface alu_operand_stage_if #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
);
    logic                 id_valid;
    logic                 id_ready;
    logic [XLEN-1:0]      id_pc;
    logic [NREG_BITS-1:0] id_rs1_addr;
    logic [NREG_BITS-1:0] id_rs2_addr;
    logic [NREG_BITS-1:0] id_rd_addr;
    logic [XLEN-1:0]      id_rs1_data;
    logic [XLEN-1:0]      id_rs2_data;
    logic [XLEN-1:0]      id_imm;
    logic [2:0]           id_funct3;
    logic                 id_funct7b5;
    logic [1:0]           id_class;
    logic [1:0]           id_src_a;
    logic [1:0]           id_src_b;
    logic                 id_is_load;
    logic                 id_is_store;
    logic                 id_regwrite;
    logic                 flush;
    logic                 ex_ready;

    logic                 ex_valid;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [3:0]           field;
    logic [NREG_BITS-1:0] ex_rd;
    logic                 ex_regwrite;
    logic                 ex_is_load;
    logic [XLEN-1:0]      ex_store_data;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7b5,
               id_class, id_src_a, id_src_b, id_is_load, id_is_store,
               id_regwrite, flush, ex_ready,
        input  id_ready, ex_valid, op1, op2, field, ex_rd, ex_regwrite,
               ex_is_load, ex_store_data
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_funct3, id_funct7b5,
               id_class, id_src_a, id_src_b, id_is_load, id_is_store,
               id_regwrite, flush, ex_ready,
        output id_ready, ex_valid, op1, op2, field, ex_rd, ex_regwrite,
               ex_is_load, ex_store_data
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: it registers decoded instructions, forwards from EX/MEM and MEM/WB, and inserts load-use bubbles.
// Defining STAGE_PERF_CNT_EN enables the stall/flush performance counters; otherwise both outputs are tied to 0.
module alu_operand_stage #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_stage_if.slave   bus,
    input  logic [NREG_BITS-1:0] exm_rd,
    input  logic                 exm_we,
    input  logic [XLEN-1:0]      exm_data,
    input  logic [NREG_BITS-1:0] wb_rd,
    input  logic                 wb_we,
    input  logic [XLEN-1:0]      wb_data,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);
    logic                 ex_valid_reg;
    logic                 ex_is_load_reg;
    logic                 ex_regwrite_reg;
    logic [NREG_BITS-1:0] ex_rd_reg;
    logic [XLEN-1:0]      pc_reg;
    logic [XLEN-1:0]      imm_reg;
    logic [1:0]           src_a_reg;
    logic [1:0]           src_b_reg;
    logic [3:0]           field_reg;
    logic [3:0]           field_next;
    logic [XLEN-1:0]      op1_next;
    logic [XLEN-1:0]      op2_next;

    logic hazard;
    logic advance;
    logic capture;
    logic hold;

    // A live load in the stage blocks any incoming instruction that reads its destination.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid_reg && ex_is_load_reg && (ex_rd_reg != '0)) begin
            if ((bus.id_src_a == 2'd0) && (bus.id_rs1_addr == ex_rd_reg))
                hazard = 1'b1;
            if (((bus.id_src_b == 2'd0) || bus.id_is_store) && (bus.id_rs2_addr == ex_rd_reg))
                hazard = 1'b1;
        end
    end

    assign advance     = ~ex_valid_reg | bus.ex_ready;
    assign capture     = ~bus.flush & advance & bus.id_valid & ~hazard;
    assign hold        = ~bus.flush & ~advance;
    assign bus.id_ready = advance & ~hazard;

    always_comb begin
        field_next = 4'b0000;
        case (bus.id_class)
            2'd0:    field_next = {bus.id_funct7b5, bus.id_funct3};
            2'd1:    field_next = {bus.id_funct7b5 & (bus.id_funct3 == 3'b101), bus.id_funct3};
            2'd2:    field_next = 4'b0000;
            default: field_next = 4'b1000;
        endcase
    end

    // Each source operand has a registered address and value plus a forwarding mux.
    // While the stage stalls, the value is rewritten with the forwarded result, so a producer that retires mid-stall is kept.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_opnd
            logic [NREG_BITS-1:0] addr_reg;
            logic [XLEN-1:0]      data_reg;
            logic [XLEN-1:0]      fwd;
            logic [NREG_BITS-1:0] id_addr;
            logic [XLEN-1:0]      id_data;

            assign id_addr = (gi == 0) ? bus.id_rs1_addr : bus.id_rs2_addr;
            assign id_data = (gi == 0) ? bus.id_rs1_data : bus.id_rs2_data;

            always_comb begin
                fwd = data_reg;
                if (addr_reg == '0)
                    fwd = '0;
                else if (exm_we && (exm_rd == addr_reg))
                    fwd = exm_data;
                else if (wb_we && (wb_rd == addr_reg))
                    fwd = wb_data;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (capture) begin
                    addr_reg <= id_addr;
                    data_reg <= id_data;
                end else if (hold) begin
                    data_reg <= fwd;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_is_load_reg  <= 1'b0;
            ex_regwrite_reg <= 1'b0;
            ex_rd_reg       <= '0;
            pc_reg          <= '0;
            imm_reg         <= '0;
            src_a_reg       <= 2'd0;
            src_b_reg       <= 2'd0;
            field_reg       <= 4'b0000;
        end else begin
            if (bus.flush)
                ex_valid_reg <= 1'b0;
            else if (advance)
                ex_valid_reg <= bus.id_valid & ~hazard;
            if (capture) begin
                ex_is_load_reg  <= bus.id_is_load;
                ex_regwrite_reg <= bus.id_regwrite;
                ex_rd_reg       <= bus.id_rd_addr;
                pc_reg          <= bus.id_pc;
                imm_reg         <= bus.id_imm;
                src_a_reg       <= bus.id_src_a;
                src_b_reg       <= bus.id_src_b;
                field_reg       <= field_next;
            end
        end
    end

    always_comb begin
        op1_next = '0;
        case (src_a_reg)
            2'd0:    op1_next = gen_opnd[0].fwd;
            2'd1:    op1_next = pc_reg;
            default: op1_next = '0;
        endcase
    end

    always_comb begin
        op2_next = '0;
        case (src_b_reg)
            2'd0:    op2_next = gen_opnd[1].fwd;
            2'd1:    op2_next = imm_reg;
            2'd2:    op2_next = XLEN'(32'd4);
            default: op2_next = '0;
        endcase
    end

    assign bus.ex_valid      = ex_valid_reg;
    assign bus.op1           = op1_next;
    assign bus.op2           = op2_next;
    assign bus.field         = field_reg;
    assign bus.ex_rd         = ex_rd_reg;
    assign bus.ex_regwrite   = ex_regwrite_reg;
    assign bus.ex_is_load    = ex_is_load_reg;
    assign bus.ex_store_data = gen_opnd[1].fwd;

`ifdef STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (bus.id_valid && hazard)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (bus.flush && ex_valid_reg)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that generates the ALU's inputs: op1, op2 and the 4-bit field ({funct7[5] or 0, funct3}).
- Registers decoded instructions and applies EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Sits between the decoder and the ALU; drives the ALU combinationally from its stage register.

Parameters:
- XLEN, 32, datapath width.
- NREG_BITS, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decoded instruction available
- id_ready  out  1  stage accepts id_* this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register addresses
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  instruction bit 30
- id_class  in  2  0 R-ALU, 1 I-ALU, 2 force-ADD (load/store/lui/auipc/jal/jalr), 3 branch
- id_src_a  in  2  op1 source: 0 rs1, 1 pc, 2 zero
- id_src_b  in  2  op2 source: 0 rs2, 1 imm, 2 constant 4
- id_is_load, id_is_store, id_regwrite  in  1 each  control bits
- flush  in  1  kill the instruction held in the stage
- ex_ready  in  1  EX consumes the stage this cycle
- exm_rd, exm_we, exm_data  in  5/1/XLEN  EX/MEM write-back candidate
- wb_rd, wb_we, wb_data  in  5/1/XLEN  MEM/WB write-back candidate
- ex_valid  out  1  stage holds a live instruction
- op1, op2  out  XLEN each  ALU operands
- field  out  4  ALU operation code
- ex_rd  out  5  destination register
- ex_regwrite, ex_is_load  out  1 each  registered control bits
- ex_store_data  out  XLEN  forwarded rs2 value
- stall_cnt, flush_cnt  out  32 each  performance counters

Behaviour:
- Reset: ex_valid=0; every stage register is 0; op1=op2=0, field=0, ex_rd=0; counters=0. Reset mid-stall drops the held instruction.
- Hazard (combinational):
  - The stage holds a live load: ex_valid & ex_is_load & ex_rd≠0.
  - And the incoming instruction reads that register: (id_src_a==0 & id_rs1_addr==ex_rd) or ((id_src_b==0 | id_is_store) & id_rs2_addr==ex_rd).
- id_ready = (~ex_valid | ex_ready) & ~hazard.
- Stage update, highest priority first:
  - flush → ex_valid<=0; the ID instruction is not captured. flush wins over a simultaneous id_valid.
  - Else if (~ex_valid | ex_ready): id_valid & ~hazard → capture all id_*, ex_valid<=1; otherwise ex_valid<=0 (bubble).
  - Else (hold): registered rs1/rs2 data refresh with their forwarded values each cycle, so producers retiring during the stall are not lost.
- Forwarding per operand: EX/MEM wins over MEM/WB, which wins over the register value. A match needs we=1, rd≠0 and rd==source address. x0 always reads 0.
- op1 by src_a: forwarded rs1, pc, or 0. op2 by src_b: forwarded rs2, imm, or 4. ex_store_data = forwarded rs2.
- field:
  - class 0 → {funct7b5, funct3}.
  - class 1 → {funct7b5 & (funct3==3'b101), funct3}; ADDI/SLTI etc. never become SUB.
  - class 2 → 4'b0000.
  - class 3 → 4'b1000; EX uses zero/sign/overflow/carry.
- Latency: one cycle from ID acceptance to operands valid. Throughput: one instruction per cycle with no hazard.
- A load-use hazard costs exactly one bubble cycle. The consumer is accepted the cycle after the load leaves.

Optional Feature:
- STAGE_PERF_CNT_EN defined:
  - stall_cnt increments on each cycle with id_valid & hazard.
  - flush_cnt increments on each cycle with flush & ex_valid.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, class 0, funct7b5=0 → next cycle op1=5, op2=7, field=0000, ex_valid=1.
- ADDI with imm=0xFFFFFC00 (bit10 set), class 1, funct3=000 → field=0000. SRAI with funct7b5=1, funct3=101 → field=1101.
- EX/MEM and MEM/WB both write x1 (exm_data=0xAA, wb_data=0xBB) → op1=0xAA. With exm_rd=0, the x0 source gives op1=0.
- LW x4 in stage, then ADD x5,x4,x1 presented → id_ready=0 for one cycle; bubble (ex_valid=0), then consumer accepted; stall_cnt=1 with macro.
- ex_ready=0 for 3 cycles while wb_we writes rs2 once → held op2 retains the WB value after wb_we drops.
- flush and id_valid in the same cycle → ex_valid=0 next; rst asserted mid-hold → all outputs 0 immediately (asynchronous).
